// File: rtl/sample_window_4.sv
// Serial-to-parallel 4-bit window assembler with valid/ready on both sides.
// SLIDE=0 delivers non-overlapping blocks; SLIDE=1 advances one bit per accepted input.
module sample_window_4 #(
   parameter bit SLIDE = 1'b0
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       clear,
   input  logic       in_bit,
   input  logic       in_valid,
   output logic       in_ready,
   output logic       win_a,
   output logic       win_b,
   output logic       win_c,
   output logic       win_d,
   output logic       win_valid,
   input  logic       win_ready,
   output logic [2:0] fill_cnt,
   output logic [7:0] win_count
);

   localparam int unsigned W_FILL = 3;
   localparam int unsigned W_CNT  = 8;
   localparam int unsigned W_WIN  = 4;
   localparam logic [W_FILL-1:0] FULL_CNT = W_FILL'(4);

   logic [W_WIN-1:0]  sr, sr_nxt;
   logic [W_FILL-1:0] fill_nxt;
   logic [W_CNT-1:0]  count_nxt;
   logic              valid_nxt;
   logic              in_acc, out_acc;

   // State register: window bits, occupancy, presented flag and delivery counter
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sr        <= '0;
         fill_cnt  <= '0;
         win_valid <= 1'b0;
         win_count <= '0;
      end else begin
         sr        <= sr_nxt;
         fill_cnt  <= fill_nxt;
         win_valid <= valid_nxt;
         win_count <= count_nxt;
      end
   end

   // Next state; the FULL state is fill_cnt == 4, win_valid mirrors it
   always_comb begin
      sr_nxt    = sr;
      fill_nxt  = fill_cnt;
      count_nxt = win_count;
      in_acc    = in_valid & in_ready;
      out_acc   = win_valid & win_ready;
      if (clear) begin
         fill_nxt = '0;
      end else begin
         if (out_acc) count_nxt = win_count + W_CNT'(1);
         if (in_acc)  sr_nxt    = {sr[W_WIN-2:0], in_bit};
         if (fill_cnt != FULL_CNT) begin
            if (in_acc) fill_nxt = fill_cnt + W_FILL'(1);
         end else if (out_acc) begin
            // in_acc implies out_acc while full, since in_ready == win_ready there
            if (SLIDE) fill_nxt = in_acc ? FULL_CNT : W_FILL'(3);
            else       fill_nxt = in_acc ? W_FILL'(1) : W_FILL'(0);
         end
      end
      valid_nxt = (fill_nxt == FULL_CNT);
   end

   // Outputs: the window is the shift register itself, oldest bit first
   always_comb begin
      in_ready = ~clear & ((fill_cnt < FULL_CNT) | win_ready);
      win_a    = sr[3];
      win_b    = sr[2];
      win_c    = sr[1];
      win_d    = sr[0];
   end

endmodule

// File: tb/tb_sample_window_4.sv
// Bench for sample_window_4: one block-mode and one sliding-mode instance share stimulus,
// each compared against a queue-based model of the windowing rules.
module tb_sample_window_4;

   logic clk = 1'b0;
   logic rst_n, clear, in_bit, in_valid, win_ready;

   logic       in_ready0, win_a0, win_b0, win_c0, win_d0, win_valid0;
   logic [2:0] fill_cnt0;
   logic [7:0] win_count0;
   logic       in_ready1, win_a1, win_b1, win_c1, win_d1, win_valid1;
   logic [2:0] fill_cnt1;
   logic [7:0] win_count1;

   int checks = 0;
   int errors = 0;

   typedef bit bq_t[$];
   bq_t mq0, mq1;
   int  mc0 = 0, mc1 = 0;

   typedef struct {
      bit       c, v, b, w;
      bit       e_rdy;
      bit [2:0] e_fill;
      bit       e_valid;
      bit [3:0] e_win;
      bit [7:0] e_cnt;
   } vec_t;
   vec_t vecs[15];

   sample_window_4 #(.SLIDE(1'b0)) dut0 (
      .clk(clk), .rst_n(rst_n), .clear(clear), .in_bit(in_bit), .in_valid(in_valid),
      .in_ready(in_ready0), .win_a(win_a0), .win_b(win_b0), .win_c(win_c0), .win_d(win_d0),
      .win_valid(win_valid0), .win_ready(win_ready), .fill_cnt(fill_cnt0), .win_count(win_count0)
   );

   sample_window_4 #(.SLIDE(1'b1)) dut1 (
      .clk(clk), .rst_n(rst_n), .clear(clear), .in_bit(in_bit), .in_valid(in_valid),
      .in_ready(in_ready1), .win_a(win_a1), .win_b(win_b1), .win_c(win_c1), .win_d(win_d1),
      .win_valid(win_valid1), .win_ready(win_ready), .fill_cnt(fill_cnt1), .win_count(win_count1)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic bit exp_rdy(input bq_t q, input bit c, input bit w);
      return !c && (q.size() < 4 || w);
   endfunction

   // Reference: the window is simply the list of held bits, oldest first
   task automatic model_step(input bit slide, input bit c, input bit v, input bit b,
                             input bit w, inout bq_t q, inout int cnt);
      bit full, rdy;
      full = (q.size() == 4);
      rdy  = exp_rdy(q, c, w);
      if (c) begin
         q.delete();
      end else begin
         if (full && w) begin
            cnt++;
            if (slide) void'(q.pop_front());
            else       q.delete();
         end
         if (v && rdy) q.push_back(b);
      end
   endtask

   task automatic check_outputs();
      chk("fill0",  32'(fill_cnt0), mq0.size());
      chk("valid0", 32'(win_valid0), 32'(mq0.size() == 4));
      chk("count0", 32'(win_count0), mc0 % 256);
      if (mq0.size() == 4)
         chk("win0", {win_a0, win_b0, win_c0, win_d0}, {mq0[0], mq0[1], mq0[2], mq0[3]});
      chk("fill1",  32'(fill_cnt1), mq1.size());
      chk("valid1", 32'(win_valid1), 32'(mq1.size() == 4));
      chk("count1", 32'(win_count1), mc1 % 256);
      if (mq1.size() == 4)
         chk("win1", {win_a1, win_b1, win_c1, win_d1}, {mq1[0], mq1[1], mq1[2], mq1[3]});
   endtask

   task automatic pre(input bit c, input bit v, input bit b, input bit w);
      @(negedge clk);
      clear = c; in_valid = v; in_bit = b; win_ready = w;
      #1;
      chk("in_ready0", 32'(in_ready0), 32'(exp_rdy(mq0, c, w)));
      chk("in_ready1", 32'(in_ready1), 32'(exp_rdy(mq1, c, w)));
      model_step(1'b0, c, v, b, w, mq0, mc0);
      model_step(1'b1, c, v, b, w, mq1, mc1);
   endtask

   task automatic post();
      @(posedge clk);
      #1;
      check_outputs();
   endtask

   task automatic step(input bit c, input bit v, input bit b, input bit w);
      pre(c, v, b, w);
      post();
   endtask

   function automatic vec_t mk(input bit c, input bit v, input bit b, input bit w, input bit r,
                               input bit [2:0] f, input bit val, input bit [3:0] win,
                               input bit [7:0] cnt);
      vec_t t;
      t.c = c; t.v = v; t.b = b; t.w = w; t.e_rdy = r;
      t.e_fill = f; t.e_valid = val; t.e_win = win; t.e_cnt = cnt;
      return t;
   endfunction

   initial begin
      int c0;
      bit done;
      rst_n = 1'b0; clear = 1'b0; in_bit = 1'b0; in_valid = 1'b0; win_ready = 1'b0;

      // Block mode: one 1011 window, then backpressure on a 1111 window
      vecs[0]  = mk(0, 1, 1, 1, 1, 3'd1, 0, 4'b0000, 8'd0);
      vecs[1]  = mk(0, 1, 0, 1, 1, 3'd2, 0, 4'b0000, 8'd0);
      vecs[2]  = mk(0, 1, 1, 1, 1, 3'd3, 0, 4'b0000, 8'd0);
      vecs[3]  = mk(0, 1, 1, 1, 1, 3'd4, 1, 4'b1011, 8'd0);
      vecs[4]  = mk(0, 0, 0, 1, 1, 3'd0, 0, 4'b0000, 8'd1);
      vecs[5]  = mk(0, 1, 1, 0, 1, 3'd1, 0, 4'b0000, 8'd1);
      vecs[6]  = mk(0, 1, 1, 0, 1, 3'd2, 0, 4'b0000, 8'd1);
      vecs[7]  = mk(0, 1, 1, 0, 1, 3'd3, 0, 4'b0000, 8'd1);
      vecs[8]  = mk(0, 1, 1, 0, 1, 3'd4, 1, 4'b1111, 8'd1);
      for (int i = 9; i < 14; i++) vecs[i] = mk(0, 1, 0, 0, 0, 3'd4, 1, 4'b1111, 8'd1);
      vecs[14] = mk(0, 1, 0, 1, 1, 3'd1, 0, 4'b0000, 8'd2);

      repeat (2) @(posedge clk);
      #1;
      check_outputs();
      chk("rst_win0", {win_a0, win_b0, win_c0, win_d0}, 0);
      chk("rst_win1", {win_a1, win_b1, win_c1, win_d1}, 0);
      @(negedge clk);
      rst_n = 1'b1;

      foreach (vecs[i]) begin
         pre(vecs[i].c, vecs[i].v, vecs[i].b, vecs[i].w);
         chk($sformatf("vec%0d_rdy", i), 32'(in_ready0), 32'(vecs[i].e_rdy));
         post();
         chk($sformatf("vec%0d_fill", i), 32'(fill_cnt0), 32'(vecs[i].e_fill));
         chk($sformatf("vec%0d_valid", i), 32'(win_valid0), 32'(vecs[i].e_valid));
         chk($sformatf("vec%0d_cnt", i), 32'(win_count0), 32'(vecs[i].e_cnt));
         if (vecs[i].e_valid)
            chk($sformatf("vec%0d_win", i), {win_a0, win_b0, win_c0, win_d0}, 32'(vecs[i].e_win));
      end

      // Sliding stream 0,0,0,0,1,1 yields 0000, 0001, 0011 back to back
      step(1, 0, 0, 1);
      c0 = mc1;
      for (int i = 0; i < 4; i++) step(0, 1, 0, 1);
      chk("slide_w0", {win_valid1, win_a1, win_b1, win_c1, win_d1}, 5'b1_0000);
      step(0, 1, 1, 1);
      chk("slide_w1", {win_valid1, win_a1, win_b1, win_c1, win_d1}, 5'b1_0001);
      step(0, 1, 1, 1);
      chk("slide_w2", {win_valid1, win_a1, win_b1, win_c1, win_d1}, 5'b1_0011);
      step(0, 0, 0, 1);
      chk("slide_cnt", 32'(win_count1), (c0 + 3) % 256);
      chk("slide_fill", 32'(fill_cnt1), 3);

      // Clear mid-fill drops the partial 111
      step(1, 0, 0, 1);
      c0 = mc0;
      for (int i = 0; i < 3; i++) step(0, 1, 1, 1);
      step(1, 1, 1, 1);
      chk("clear_fill", 32'(fill_cnt0), 0);
      chk("clear_valid", 32'(win_valid0), 0);
      for (int i = 0; i < 4; i++) step(0, 1, 0, 0);
      chk("clear_win", {win_valid0, win_a0, win_b0, win_c0, win_d0}, 5'b1_0000);
      step(0, 0, 0, 1);
      chk("clear_cnt", 32'(win_count0), (c0 + 1) % 256);

      // Asynchronous reset while a window is presented
      step(1, 0, 0, 1);
      for (int i = 0; i < 4; i++) step(0, 1, 1, 0);
      chk("pre_rst_valid", 32'(win_valid0 & win_valid1), 1);
      @(negedge clk);
      in_valid = 1'b0; win_ready = 1'b0; clear = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      chk("arst_0", {win_valid0, fill_cnt0, win_count0, win_a0, win_b0, win_c0, win_d0}, 0);
      chk("arst_1", {win_valid1, fill_cnt1, win_count1, win_a1, win_b1, win_c1, win_d1}, 0);
      mq0.delete(); mq1.delete(); mc0 = 0; mc1 = 0;
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check_outputs();

      // Sliding counter wrap: 256 windows return win_count to 0, the 257th gives 1
      done = 1'b0;
      for (int i = 0; i < 400 && !done; i++) begin
         step(0, 1, 1'($urandom_range(0, 1)), 1);
         if (mc1 == 256) chk("wrap0", 32'(win_count1), 0);
         if (mc1 == 257) begin
            chk("wrap1", 32'(win_count1), 1);
            done = 1'b1;
         end
      end
      chk("wrap_done", 32'(done), 1);

      // Random traffic against the model
      for (int i = 0; i < 1500; i++)
         step(1'($urandom_range(0, 24) == 0), 1'($urandom_range(0, 3) != 0),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) != 0));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/sample_window_4.md
# sample_window_4

Upstream feeder for the 4-input equality comparator. It accepts a serial bit stream over a valid/ready handshake and assembles it into 4-bit windows. Each complete window is presented as four parallel bits (win_a..win_d) with a valid/ready handshake, so the downstream comparator sees a stable, complete sample set. The block supports non-overlapping block windows and sliding windows, plus a synchronous clear.

## Interface
- SLIDE, default 0: 0 = non-overlapping blocks of 4 bits; 1 = sliding window, advancing by one bit per accepted input once filled.
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- clear  in  1  synchronous flush; drops the window in progress or presented; highest priority.
- in_bit  in  1  serial sample.
- in_valid  in  1  in_bit is valid.
- in_ready  out  1  block can accept in_bit this cycle (combinational).
- win_a  out  1  oldest bit of the window.
- win_b  out  1  second bit of the window.
- win_c  out  1  third bit of the window.
- win_d  out  1  newest bit of the window.
- win_valid  out  1  window complete and stable (registered).
- win_ready  in  1  downstream accepts the window.
- fill_cnt  out  3  bits currently held, 0..4.
- win_count  out  8  windows delivered (win_valid & win_ready), wraps 255 -> 0.

## Operation
- Storage: shift register sr[3:0], where sr[3] = win_a (oldest) and sr[0] = win_d (newest). An accepted bit shifts in at sr[0].
- Input accept = in_valid & in_ready. Output accept = win_valid & win_ready.
- States are derived from fill_cnt:
  - EMPTY: fill_cnt = 0.
  - FILL: fill_cnt = 1..3.
  - FULL: fill_cnt = 4, win_valid = 1.
- in_ready = (fill_cnt < 4) | win_ready, forced to 0 while clear = 1.
- EMPTY/FILL: each input accept shifts sr and increments fill_cnt. Reaching 4 enters FULL.
- FULL: win_a..win_d and win_valid hold until output accept. Input is stalled unless win_ready = 1.
- FULL with output accept and no input accept:
  - SLIDE=0 -> EMPTY.
  - SLIDE=1 -> fill_cnt = 3 (FILL). The newest 3 bits are retained.
- FULL with output accept and input accept in the same cycle:
  - SLIDE=0 -> fill_cnt = 1, and the new bit is the first bit of the next block.
  - SLIDE=1 -> shift sr, fill_cnt stays 4, win_valid stays 1, and the next window is presented.
- clear = 1 (any state) -> fill_cnt = 0 and win_valid = 0 next cycle. The input is not accepted and no window is delivered. sr contents are don't-care; win_count is unchanged.
- win_count increments on every output accept, modulo 256.
- Reset values: fill_cnt = 0, win_valid = 0, sr = 4'b0000 (win_a..win_d = 0), win_count = 0. in_ready = 1 once rst_n is released.
- Reset asserted mid-window discards all partial state immediately (asynchronously).

## Timing
- Latency: win_valid rises on the clock edge that accepts the 4th bit of a window. It is visible in the cycle after that accept.
- Throughput:
  - SLIDE=1 with win_ready held at 1: one window per input bit once filled.
  - SLIDE=0: one window per 4 input bits. There is no bubble between blocks when win_ready = 1 at the FULL cycle.
- in_ready depends combinationally on win_ready. There is no combinational path from in_valid to any output.
- win_a..win_d must not change while win_valid = 1 and win_ready = 0.

## Test plan
- Reset, SLIDE=0:
  - Stimulus: drive bits 1,0,1,1 with in_valid = 1 on consecutive cycles, win_ready = 1.
  - Response: win_valid = 1 one cycle after the 4th accept, with win_a..win_d = 1,0,1,1. Next cycle fill_cnt = 0 and win_count = 1.
- Backpressure:
  - Stimulus: fill with 1,1,1,1 and hold win_ready = 0 for 5 cycles while in_valid = 1 with bit 0.
  - Response: in_ready = 0, window stays 1,1,1,1, fill_cnt = 4. Releasing win_ready gives one output accept in the same cycle as the accept of bit 0, then fill_cnt = 1.
- SLIDE=1 stream:
  - Stimulus: bits 0,0,0,0,1,1, win_ready = 1.
  - Response: windows 0000, 0001, 0011 on three consecutive cycles; win_count = 3.
- Clear mid-fill:
  - Stimulus: accept 1,1,1, then clear = 1 for one cycle, then 0,0,0,0.
  - Response: only window 0000 is delivered, and fill_cnt = 0 immediately after clear.
- Async reset in FULL:
  - Stimulus: drive rst_n low while win_valid = 1, asynchronously to clk.
  - Response: win_valid, fill_cnt, win_count and win_a..win_d go to 0 without waiting for a clk edge.
- win_count wrap:
  - Stimulus: deliver 256 windows with SLIDE=1.
  - Response: win_count returns to 0, and the 257th window gives 1.
